psum_collect_fifo: RTL and testbench
====================================

Name: psum_collect_fifo

Overview:
- Receiver at the south edge of the systolic MAC array; consumes the per-column psum bus and per-column valid strobes the array emits.
- Column outputs arrive staggered by one cycle per column. The block buffers each column in its own FIFO and re-aligns the columns into full output rows.
- It presents those rows to the downstream SRAM/accumulation controller through a read handshake.

Parameters:
- psum_bw, 16, width of one column's partial sum (signed two's complement)
- col, 8, number of array columns
- depth, 64, entries per column FIFO; power of two, ≥2

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in  input  psum_bw*col  psum bus from the array; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- valid_in  input  col  per-column write strobe from the array; bit c qualifies column c of in
- rd  input  1  pop request from the downstream controller
- o_valid  output  1  a complete row is available (every column FIFO non-empty)
- o_full  output  1  at least one column FIFO is full
- o_empty  output  1  every column FIFO is empty
- out  output  psum_bw*col  registered row data, same column packing as in
- out_strobe  output  1  one-cycle pulse; out was updated this cycle
- overflow  output  col  sticky per-column overflow flag

Behaviour:
- Reset:
  - all read and write pointers go to 0; out=0, out_strobe=0, overflow=0.
  - FIFO storage is not cleared; its contents are don't-care.
  - Reset asserted mid-operation discards all buffered data the same edge. Any push or rd presented in that cycle is ignored.
- Storage and pointers:
  - One FIFO per column; the columns are independent.
  - Each FIFO has its own write pointer wp[c] and read pointer rp[c], each log2(depth)+1 bits wide. The extra MSB is the wrap bit.
  - empty[c] = (wp[c]==rp[c]).
  - full[c] = (low bits equal, MSBs differ).
- Push, column c:
  - Taken when valid_in[c]=1 and (!full[c] or pop this cycle).
  - The psum word is written at wp[c], and wp[c] increments modulo 2*depth.
  - A push into a full column in a cycle with no pop is dropped: wp[c] does not change and overflow[c] is set to 1. overflow[c] stays 1 until reset.
  - All full/empty tests use pointer values from before the clock edge.
- Pop (row read):
  - pop = rd & o_valid.
  - On pop, each column's head entry is registered into out, rp[c] increments in every column, and out_strobe=1 on the following cycle.
  - Latency: out is valid at the edge following the rd cycle. out holds its value until the next pop.
  - A rd with o_valid=0 is ignored: no pointer moves, out holds, out_strobe=0.
- Simultaneous push and pop on the same column:
  - Both take effect and the occupancy is unchanged.
  - This holds when the column is full: the push is accepted and overflow is not set.
  - This holds when the column is empty: the new data cannot be popped that cycle, because o_valid requires it to be non-empty before the edge.
- Flags:
  - o_valid = AND over columns of !empty[c]; o_full = OR of full[c]; o_empty = AND of empty[c].
  - All three are combinational from the pointers; no dependency on rd or valid_in.
- Skew:
  - No assumption is made about the arrival order between columns.
  - A row becomes poppable only after the slowest column has written. For the nominal one-cycle-per-column stagger, o_valid rises col-1 cycles after the first valid_in[0].
- Arithmetic: data passes through bit-exact. No sign handling is applied unless the optional feature is enabled.

Optional Feature:
- Macro: PSUM_RELU_EN.
- Defined: each column of the row registered into out goes through ReLU. A word whose MSB is 1 is replaced by 0; other words pass unchanged. This is applied on the pop path only; stored FIFO data stays unmodified.
- Undefined: out is bit-exact with the stored data, and no extra logic is present.

Test Plan (col=8, psum_bw=16, depth=4):
- Staggered fill: column c receives 16'h0010+c at cycle t0+c, no rd → o_valid rises at t0+8 (after col-1 stagger); rd 1 cycle → next cycle out = {16'h0017,...,16'h0010}, out_strobe=1; then o_empty=1.
- Overflow: 5 pushes to column 3 with no rd → after the 4th push o_full=1; the 5th push is dropped and overflow=8'b0000_1000. Later drain returns the first 4 values in order.
- Full with simultaneous push/pop: all columns full, rd=1 and valid_in=8'hFF in the same cycle → occupancy stays 4, overflow stays 0, and the popped row is the oldest.
- Empty read: rd=1 with o_empty=1 → out unchanged, out_strobe=0, pointers unchanged.
- Wrap-around: 10 rows pushed and popped interleaved so pointers wrap twice → out sequence matches the push order exactly, and no flag errors occur.
- Reset mid-stream: 2 rows buffered, reset for 1 cycle with rd=1 → out=0, o_empty=1, overflow=0, out_strobe=0; the next pushed row reads back correctly. With PSUM_RELU_EN, pushing 16'hFFF0 in column 0 gives 16'h0000 on out, and 16'h7FFF passes unchanged.

Source files
------------

// File: rtl/psum_collect_fifo.sv
// Column-deskew FIFO bank at the south edge of the systolic array: one FIFO per column, rows popped in lockstep.
// Optional ReLU on the pop path is enabled by defining PSUM_RELU_EN.
module psum_collect_fifo #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         valid_in,
  input  logic                   rd,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_strobe,
  output logic [col-1:0]         overflow
);

  localparam int AW = $clog2(depth);

  logic [psum_bw-1:0]     r_mem [col][depth];
  logic [AW:0]            r_wp  [col];
  logic [AW:0]            r_rp  [col];
  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_full;
  logic [col-1:0]         w_push;
  logic                   w_pop;
  logic [psum_bw*col-1:0] w_row;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int unsigned c = 0; c < col; c++) begin
      w_empty[c] = (r_wp[c] == r_rp[c]);
      w_full[c]  = (r_wp[c][AW-1:0] == r_rp[c][AW-1:0]) && (r_wp[c][AW] != r_rp[c][AW]);
    end
  end

  assign o_valid = &(~w_empty);
  assign o_full  = |w_full;
  assign o_empty = &w_empty;
  assign w_pop   = rd & o_valid;

  // A full column still accepts a push when the row is popped the same cycle.
  always_comb begin
    w_push = '0;
    for (int unsigned c = 0; c < col; c++) begin
      w_push[c] = valid_in[c] & (~w_full[c] | w_pop);
    end
  end

  always_comb begin
    w_row = '0;
    for (int unsigned c = 0; c < col; c++) begin
`ifdef PSUM_RELU_EN
      if (r_mem[c][r_rp[c][AW-1:0]][psum_bw-1]) begin
        w_row[c*psum_bw +: psum_bw] = '0;
      end else begin
        w_row[c*psum_bw +: psum_bw] = r_mem[c][r_rp[c][AW-1:0]];
      end
`else
      w_row[c*psum_bw +: psum_bw] = r_mem[c][r_rp[c][AW-1:0]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned c = 0; c < col; c++) begin
        if (w_push[c]) begin
          r_mem[c][r_wp[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < col; c++) begin
        r_wp[c] <= '0;
        r_rp[c] <= '0;
      end
      out        <= '0;
      out_strobe <= 1'b0;
      overflow   <= '0;
    end else begin
      for (int unsigned c = 0; c < col; c++) begin
        if (w_push[c]) begin
          r_wp[c] <= r_wp[c] + (AW+1)'(1);
        end
        if (w_pop) begin
          r_rp[c] <= r_rp[c] + (AW+1)'(1);
        end
        if (valid_in[c] && w_full[c] && !w_pop) begin
          overflow[c] <= 1'b1;
        end
      end
      if (w_pop) begin
        out <= w_row;
      end
      out_strobe <= w_pop;
    end
  end

endmodule

// File: tb/tb_psum_collect_fifo.sv
// Directed, table-driven bench for psum_collect_fifo (col=8, psum_bw=16, depth=4).
module tb_psum_collect_fifo;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] din;
  logic [7:0]   vin;
  logic         rd;
  logic         o_valid, o_full, o_empty, out_strobe;
  logic [127:0] dout;
  logic [7:0]   overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_collect_fifo #(.psum_bw(16), .col(8), .depth(4)) dut (
    .clk(clk), .reset(reset), .in(din), .valid_in(vin), .rd(rd),
    .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty),
    .out(dout), .out_strobe(out_strobe), .overflow(overflow)
  );

  typedef struct {
    logic         rst;
    logic [7:0]   vin;
    logic [127:0] din;
    logic         rd;
    logic         e_valid, e_full, e_empty;
    logic [127:0] e_out;
    logic         e_strobe;
    logic [7:0]   e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic logic [127:0] R(input logic [15:0] b);
    logic [127:0] r = '0;
    for (int c = 0; c < 8; c++) r[c*16 +: 16] = 16'(b + 16'(c));
    return r;
  endfunction

  function automatic logic [127:0] setc(input logic [127:0] row, input int c, input logic [15:0] v);
    logic [127:0] r = row;
    r[c*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] relu(input logic [127:0] row);
    logic [127:0] r = row;
`ifdef PSUM_RELU_EN
    for (int c = 0; c < 8; c++) if (r[c*16+15]) r[c*16 +: 16] = '0;
`endif
    return r;
  endfunction

  task automatic add(input logic rs, input logic [7:0] v, input logic [127:0] d, input logic r,
                     input logic ev, input logic ef, input logic ee,
                     input logic [127:0] eo, input logic es, input logic [7:0] eovf);
    vec_t t;
    t.rst = rs; t.vin = v; t.din = d; t.rd = r;
    t.e_valid = ev; t.e_full = ef; t.e_empty = ee;
    t.e_out = eo; t.e_strobe = es; t.e_ovf = eovf;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] x1, nrow;
    int n;

    reset = 1'b0; din = '0; vin = '0; rd = 1'b0;

    add(1, 8'h00, '0, 1, 0, 0, 1, '0, 0, 8'h00);
    // Staggered fill: column k arrives at step k.
    for (int k = 0; k < 8; k++)
      add(0, 8'(1 << k), R(16'h0010), 0, k == 7, 0, 0, '0, 0, 8'h00);
    x1 = relu(R(16'h0010));
    add(0, 8'h00, '0, 1, 0, 0, 1, x1, 1, 8'h00);
    add(0, 8'h00, '0, 0, 0, 0, 1, x1, 0, 8'h00);
    add(0, 8'h00, '0, 1, 0, 0, 1, x1, 0, 8'h00);
    // Five pushes into column 3: the fifth is dropped.
    for (int i = 0; i < 5; i++)
      add(0, 8'h08, setc('0, 3, 16'(16'h00A0 + i)), 0, 0, i >= 3, 0, x1, 0, (i == 4) ? 8'h08 : 8'h00);
    for (int i = 0; i < 4; i++)
      add(0, 8'hF7, R(16'(16'h0040 + 16 * i)), 0, 1, 1, 0, x1, 0, 8'h08);
    // Push and pop together with every column full.
    add(0, 8'hFF, R(16'h0080), 1, 1, 1, 0, relu(setc(R(16'h0040), 3, 16'h00A0)), 1, 8'h08);
    for (int j = 1; j < 4; j++)
      add(0, 8'h00, '0, 1, 1, 0, 0, relu(setc(R(16'(16'h0040 + 16 * j)), 3, 16'(16'h00A0 + j))), 1, 8'h08);
    add(0, 8'h00, '0, 1, 0, 0, 1, relu(R(16'h0080)), 1, 8'h08);
    add(0, 8'h00, '0, 1, 0, 0, 1, relu(R(16'h0080)), 0, 8'h08);
    // Reset with two rows buffered and rd/push asserted.
    add(0, 8'hFF, R(16'h0090), 0, 1, 0, 0, relu(R(16'h0080)), 0, 8'h08);
    add(0, 8'hFF, R(16'h00A0), 0, 1, 0, 0, relu(R(16'h0080)), 0, 8'h08);
    add(1, 8'hFF, R(16'h00B0), 1, 0, 0, 1, '0, 0, 8'h00);
    add(0, 8'hFF, R(16'h00C0), 0, 1, 0, 0, '0, 0, 8'h00);
    add(0, 8'h00, '0, 1, 0, 0, 1, relu(R(16'h00C0)), 1, 8'h00);
    // Ten interleaved rows so the pointers wrap.
    add(0, 8'hFF, R(16'h0100), 0, 1, 0, 0, relu(R(16'h00C0)), 0, 8'h00);
    for (int j = 1; j < 10; j++)
      add(0, 8'hFF, R(16'(16'h0100 + 16 * j)), 1, 1, 0, 0, relu(R(16'(16'h0100 + 16 * (j - 1)))), 1, 8'h00);
    add(0, 8'h00, '0, 1, 0, 0, 1, relu(R(16'h0190)), 1, 8'h00);
    // Negative and max-positive words on the pop path.
    nrow = setc(setc(R(16'h0010), 0, 16'hFFF0), 1, 16'h7FFF);
    add(0, 8'hFF, nrow, 0, 1, 0, 0, relu(R(16'h0190)), 0, 8'h00);
    add(0, 8'h00, '0, 1, 0, 0, 1, relu(nrow), 1, 8'h00);

    foreach (vq[i]) begin
      reset = vq[i].rst; vin = vq[i].vin; din = vq[i].din; rd = vq[i].rd;
      step();
      chk("o_valid", i, 128'(o_valid), 128'(vq[i].e_valid));
      chk("o_full", i, 128'(o_full), 128'(vq[i].e_full));
      chk("o_empty", i, 128'(o_empty), 128'(vq[i].e_empty));
      chk("out", i, dout, vq[i].e_out);
      chk("out_strobe", i, 128'(out_strobe), 128'(vq[i].e_strobe));
      chk("overflow", i, 128'(overflow), 128'(vq[i].e_ovf));
    end

    // Reverse skew: column 7 first, column 0 last.
    reset = 1'b0; rd = 1'b0; din = R(16'h0200);
    for (int k = 7; k >= 0; k--) begin
      vin = 8'(1 << k);
      step();
      chk("skew_valid", k, 128'(o_valid), 128'(k == 0));
    end
    vin = '0;
    n = 0;
    while (!o_valid && n < 10) begin
      step();
      n++;
    end
    chk("skew_wait", n, 128'(o_valid), 128'(1));
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("skew_out", 0, dout, relu(R(16'h0200)));
    chk("skew_strobe", 0, 128'(out_strobe), 128'(1));
    chk("skew_empty", 0, 128'(o_empty), 128'(1));
    chk("skew_ovf", 0, 128'(overflow), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
